// File: rtl/delay_pkg.sv
// Shared constants and helpers for the programmable delay line and the
// top-level channel-select mux that feeds it preset delay values.
package delay_pkg;

    localparam int DL_WIDTH      = 8;
    localparam int DL_MAX_DEPTH  = 90;
    localparam int DL_INIT_DELAY = 30;

    // Channel-select codes of the top-level output mux.
    typedef enum logic [1:0] {
        CH_D30 = 2'b00,
        CH_D45 = 2'b01,
        CH_D60 = 2'b10,
        CH_D90 = 2'b11
    } ch_sel_e;

    function automatic int preset_delay(input ch_sel_e sel);
        case (sel)
            CH_D30:  return 30;
            CH_D45:  return 45;
            CH_D60:  return 60;
            default: return 90;
        endcase
    endfunction

    // A delay of zero is meaningless; anything past the ring length saturates.
    function automatic int clamp_delay(input int req, input int max_depth);
        if (req <= 0) return 1;
        if (req > max_depth) return max_depth;
        return req;
    endfunction

endpackage

// File: rtl/delay_ring_ram.sv
// DEPTH x WIDTH sample ring: one synchronous write port, one asynchronous
// read port, no reset on the contents.
module delay_ring_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 90,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line: delays din by delay_q enabled edges using a
// circular buffer, masking output to zero until the line has refilled.
module prog_delay_line
    import delay_pkg::*;
#(
    parameter int WIDTH      = DL_WIDTH,
    parameter int MAX_DEPTH  = DL_MAX_DEPTH,
    parameter int INIT_DELAY = DL_INIT_DELAY,
    parameter int DW         = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic [DW-1:0]    delay_in,
    input  logic             load,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [DW-1:0]    delay_q
);

    localparam int AW = $clog2(MAX_DEPTH);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    wptr_next;
    logic [AW-1:0]    back;
    logic [AW-1:0]    raddr;
    logic [DW-1:0]    fill;
    logic [DW-1:0]    new_delay;
    logic [DW-1:0]    d_eff;
    logic [DW-1:0]    fill_base;
    logic [DW-1:0]    fill_inc;
    logic             ready;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] sample;

    delay_ring_ram #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (en),
        .waddr (wptr),
        .wdata (din),
        .raddr (raddr),
        .rdata (rd_data)
    );

    assign new_delay = DW'(clamp_delay(int'(delay_in), MAX_DEPTH));
    assign wptr_next = (wptr == AW'(MAX_DEPTH - 1)) ? '0 : wptr + 1'b1;

    // The entry D-1 slots behind wptr holds the sample that leaves at this edge.
    assign back  = AW'(delay_q - 1'b1);
    assign raddr = (wptr >= back) ? wptr - back
                                  : wptr + (AW'(MAX_DEPTH) - back);

    // A load at this edge restarts the fill under the new delay; the sample
    // accepted on the same edge becomes the first one of the new line.
    always_comb begin
        d_eff     = load ? new_delay : delay_q;
        fill_base = load ? '0 : fill;
        fill_inc  = (fill_base == d_eff) ? fill_base : fill_base + 1'b1;
        ready     = (fill_inc == d_eff);
        sample    = (d_eff == DW'(1)) ? din : rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            fill    <= '0;
            delay_q <= DW'(INIT_DELAY);
            dout    <= '0;
            valid   <= 1'b0;
        end else begin
            if (load) begin
                delay_q <= new_delay;
            end
            if (en) begin
                wptr  <= wptr_next;
                fill  <= fill_inc;
                valid <= ready;
                dout  <= ready ? sample : '0;
            end else if (load) begin
                fill  <= '0;
                valid <= 1'b0;
                dout  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prog_delay_line.sv
// Bench for prog_delay_line: directed table, corner sequences and random
// traffic checked against a sample-window reference model.
module tb_prog_delay_line;
    import delay_pkg::*;

    localparam int WIDTH      = DL_WIDTH;
    localparam int MAX_DEPTH  = DL_MAX_DEPTH;
    localparam int INIT_DELAY = DL_INIT_DELAY;
    localparam int DW         = $clog2(MAX_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [DW-1:0]    delay_in = '0;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic [DW-1:0]    delay_q;

    int errors = 0;
    int checks = 0;

    // Reference model: window of accepted samples since last reset/load.
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_valid = 1'b0;
    int               m_delay = INIT_DELAY;

    typedef struct {
        logic             en;
        logic             load;
        int               delay_in;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp_dout;
        logic             exp_valid;
        int               exp_delay;
    } vec_t;

    vec_t vecs[15];

    prog_delay_line #(
        .WIDTH      (WIDTH),
        .MAX_DEPTH  (MAX_DEPTH),
        .INIT_DELAY (INIT_DELAY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .din      (din),
        .delay_in (delay_in),
        .load     (load),
        .dout     (dout),
        .valid    (valid),
        .delay_q  (delay_q)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_delay = INIT_DELAY;
    endtask

    task automatic model_edge(input logic e, input logic l, input int di, input logic [WIDTH-1:0] d);
        if (l) begin
            m_delay = (di == 0) ? 1 : ((di > MAX_DEPTH) ? MAX_DEPTH : di);
            exp_q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
        end
        if (e) begin
            exp_q.push_back(d);
            if (exp_q.size() > m_delay) void'(exp_q.pop_front());
            if (exp_q.size() == m_delay) begin
                m_dout  = exp_q[0];
                m_valid = 1'b1;
            end else begin
                m_dout  = '0;
                m_valid = 1'b0;
            end
        end
    endtask

    // Driver: one clock cycle with the given inputs, then compare to the model.
    task automatic step(input logic e, input logic l, input int di, input logic [WIDTH-1:0] d);
        @(negedge clk);
        en       = e;
        load     = l;
        delay_in = DW'(di);
        din      = d;
        @(posedge clk);
        model_edge(e, l, di, d);
        #1;
        check("dout", 32'(dout), 32'(m_dout));
        check("valid", 32'(valid), 32'(m_valid));
        check("delay_q", 32'(delay_q), 32'(m_delay));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dout"}, 32'(dout), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_delay_q"}, 32'(delay_q), 32'(INIT_DELAY));
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        model_reset();
        repeat (3) begin
            @(negedge clk);
            en = ~en;
        end
        #1;
        check_reset_state("rst_hold");
        @(negedge clk);
        en    = 1'b0;
        load  = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic ramp_after_reset(input string tag);
        for (int i = 1; i <= 35; i++) begin
            step(1'b1, 1'b0, 0, WIDTH'(i));
            if (i == 29) check({tag, "_valid29"}, 32'(valid), 32'd0);
            if (i == 30) check({tag, "_dout30"}, 32'(dout), 32'd1);
            if (i == 35) check({tag, "_dout35"}, 32'(dout), 32'd6);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] s1;
        logic [WIDTH-1:0] d;
        logic             en_pat [8];

        // Directed table: clamp, D=1, repeated load, stale-data masking.
        vecs[0]  = '{1'b0, 1'b1, 0,   8'h00, 8'h00, 1'b0, 1};
        vecs[1]  = '{1'b1, 1'b0, 0,   8'h11, 8'h11, 1'b1, 1};
        vecs[2]  = '{1'b1, 1'b0, 0,   8'h22, 8'h22, 1'b1, 1};
        vecs[3]  = '{1'b0, 1'b0, 0,   8'h33, 8'h22, 1'b1, 1};
        vecs[4]  = '{1'b0, 1'b1, 127, 8'h00, 8'h00, 1'b0, 90};
        vecs[5]  = '{1'b1, 1'b1, 2,   8'h44, 8'h00, 1'b0, 2};
        vecs[6]  = '{1'b1, 1'b0, 0,   8'h55, 8'h44, 1'b1, 2};
        vecs[7]  = '{1'b1, 1'b0, 0,   8'h66, 8'h55, 1'b1, 2};
        vecs[8]  = '{1'b1, 1'b1, 1,   8'h77, 8'h77, 1'b1, 1};
        vecs[9]  = '{1'b0, 1'b1, 1,   8'h00, 8'h00, 1'b0, 1};
        vecs[10] = '{1'b1, 1'b0, 0,   8'h88, 8'h88, 1'b1, 1};
        vecs[11] = '{1'b0, 1'b1, 3,   8'h00, 8'h00, 1'b0, 3};
        vecs[12] = '{1'b1, 1'b0, 0,   8'h01, 8'h00, 1'b0, 3};
        vecs[13] = '{1'b1, 1'b0, 0,   8'h02, 8'h00, 1'b0, 3};
        vecs[14] = '{1'b1, 1'b0, 0,   8'h03, 8'h01, 1'b1, 3};
        en_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset held with en toggling.
        model_reset();
        repeat (4) begin
            @(negedge clk);
            en = ~en;
            #1;
            check_reset_state("reset");
        end
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        ramp_after_reset("ramp");

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].load, vecs[i].delay_in, vecs[i].din);
            check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_delay", i), 32'(delay_q), 32'(vecs[i].exp_delay));
        end

        // D=1 acts as a plain register.
        step(1'b0, 1'b1, 1, '0);
        for (int i = 0; i < 6; i++) begin
            d = WIDTH'($urandom);
            step(1'b1, 1'b0, 0, d);
            check("d1_dout", 32'(dout), 32'(d));
        end

        // D=MAX across several pointer wraps.
        step(1'b0, 1'b1, MAX_DEPTH, '0);
        s1 = '0;
        for (int i = 1; i <= 3 * MAX_DEPTH + 20; i++) begin
            d = WIDTH'($urandom);
            if (i == 1) s1 = d;
            step(1'b1, 1'b0, 0, d);
            if (i == MAX_DEPTH - 1) check("dmax_valid89", 32'(valid), 32'd0);
            if (i == MAX_DEPTH) check("dmax_first", 32'(dout), 32'(s1));
        end

        // Mid-stream change from 30 to 45 with load and en together.
        step(1'b0, 1'b1, preset_delay(CH_D30), '0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 0, WIDTH'($urandom));
        s1 = WIDTH'($urandom);
        step(1'b1, 1'b1, preset_delay(CH_D45), s1);
        check("mid_valid_drop", 32'(valid), 32'd0);
        for (int i = 2; i <= 45; i++) begin
            step(1'b1, 1'b0, 0, WIDTH'($urandom));
            if (i == 44) check("mid_dout44", 32'(dout), 32'd0);
            if (i == 45) check("mid_first", 32'(dout), 32'(s1));
        end

        // Stalls at D=5.
        step(1'b0, 1'b1, 5, '0);
        for (int i = 0; i < 8; i++) begin
            step(en_pat[i], 1'b0, 0, WIDTH'(8'hA1 + i));
            if (i == 6) check("stall_valid", 32'(valid), 32'd0);
        end
        check("stall_dout", 32'(dout), 32'(8'hA1));
        check("stall_valid_end", 32'(valid), 32'd1);
        step(1'b0, 1'b0, 0, 8'hEE);
        check("stall_hold", 32'(dout), 32'(8'hA1));

        // Async reset while valid, then refill.
        check("pre_rst_valid", 32'(valid), 32'd1);
        async_reset();
        ramp_after_reset("refill");

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic e;
            logic l;
            int   di;
            e  = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 40) == 0);
            di = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 127);
            step(e, l, di, WIDTH'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_delay_line.md
# prog_delay_line

Single-channel, runtime-programmable digital delay line. It delays a WIDTH-bit sample stream by D enabled clock cycles, where D is loaded at run time in the range 1..MAX_DEPTH. It replaces the fixed-length 30/45/60/90-stage shift chains behind the top-level output mux with one circular buffer per channel. It adds clock-enable stalling, delay clamping, zero-fill after a delay change, and a valid flag.

## Interface
Parameters:
- WIDTH, 8, sample width in bits
- MAX_DEPTH, 90, largest supported delay (≥2)
- INIT_DELAY, 30, delay active after reset (1..MAX_DEPTH)
- DW, $clog2(MAX_DEPTH+1), width of the delay port (derived, not overridden)

Ports (one clock; reset asynchronous, active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  advance enable; when low, all state holds
- din  in  WIDTH  input sample, accepted on enabled edges
- delay_in  in  DW  requested delay, captured when load=1
- load  in  1  apply delay_in at this edge (independent of en)
- dout  out  WIDTH  delayed sample, registered
- valid  out  1  dout carries a real sample (line filled since last reset/load)
- delay_q  out  DW  currently active (clamped) delay

## Operation
- Storage: ring of MAX_DEPTH entries, write pointer wptr in 0..MAX_DEPTH-1, wraps MAX_DEPTH-1 → 0.
- Enabled edge (en=1): din written at wptr, wptr advances, fill counter increments (saturates at delay_q), dout updated.
- Output rule: number enabled edges since last reset/load k=1,2,…; sample s_j is accepted at edge j. After edge k:
  - k ≥ D: dout = s_{k−D+1}, valid=1.
  - otherwise: dout=0, valid=0.
- D=1 behaves as a plain register.
- en=0: dout, valid, wptr and fill counter hold; din is ignored.
- Load: delay_q ← clamp(delay_in). Clamping: 0 → 1, >MAX_DEPTH → MAX_DEPTH. Fill counter clears and valid drops.
- Buffer contents are not flushed on load. The zero mask hides stale data until the line refills at the new delay.
- Simultaneous load and en: the sample accepted at that edge is s_1 of the new delay.
- Repeated load with the same value still restarts the fill.
- Storage array is not reset. The zero mask guarantees dout=0 until filled.
- Reset (async, any time, including mid-stream):
  - dout=0, valid=0, delay_q=INIT_DELAY, wptr=0, fill=0.
  - Operation restarts cleanly on the first edge after rst_n rises.

## Timing
- Latency: exactly D enabled edges from din sampled to dout. Stall cycles (en=0) are not counted.
- First valid output: after the D-th enabled edge following reset/load.
- Load effect: delay_q and valid change at the load edge itself. The new delay governs dout from that edge on.
- Read address is wptr−(D−1) modulo MAX_DEPTH, with wrap correction. Requirements:
  - no combinational path from delay_in to dout;
  - dout driven directly by a flop;
  - read of the entry written at the same edge (D=1) is bypassed from din.
- All state is updated on the rising edge of clk only; no combinational outputs.

## Structure
- Shared package delay_pkg holds:
  - default constants DL_WIDTH=8, DL_MAX_DEPTH=90, DL_INIT_DELAY=30;
  - the clamp function for delay values;
  - the top-level channel-select encodings (00→30, 01→45, 10→60, 11→90), shared with the top-level mux so presets map to delay_in values.
- One sub-module: delay_ring_ram, a MAX_DEPTH×WIDTH array with one synchronous write port and one read port, no reset.
- Pointer arithmetic, fill counter, clamp, mask and bypass live in prog_delay_line.

## Test plan
- Reset: hold rst_n=0 with en toggling → dout=0, valid=0, delay_q=30. Release, drive ramp din=1,2,3… with en=1 → valid rises after edge 30 with dout=1, then 2, 3….
- D=1 and D=MAX: load 1 → dout equals previous-edge din, valid one edge after load. Load 90 → first valid dout=s_1 after 90 edges, continuous across ≥3 pointer wraps.
- Mid-stream change: running at D=30, load 45 → valid drops at the load edge, dout=0 for 44 edges, then dout=s_1 (sample at load edge).
- Clamping: load delay_in=0 → delay_q=1. Load 127 → delay_q=90.
- Stalls: D=5, en pattern 1,0,0,1,1,0,1,1 with din changing every cycle → only enabled samples appear; outputs and valid hold while en=0; output appears after the 5th enabled edge.
- Async reset mid-operation: assert rst_n between clock edges while valid=1 → dout and valid clear immediately, delay_q returns to 30, refill behaves as in the reset test.
